// File: rtl/joystick_board_responder_pkg.sv
// Shared constants, FSM state type and helpers for the joystick board serial responder.
package joystick_board_responder_pkg;

  localparam int FRAME_BITS = 24;
  localparam int ROW_W      = 8;
  localparam int COL_W      = 6;
  localparam int HDR_W      = 8;
  localparam int CNT_W      = 5;

  // Bit positions of the fields inside a received frame
  localparam int HDR_LSB = 0;
  localparam int COL_LSB = 8;
  localparam int ROW_LSB = 16;

  // Column-select bit indices
  localparam int COL_SLIDE_RED    = 0;
  localparam int COL_SLIDE_GREEN  = 1;
  localparam int COL_CIRCLE_RED   = 2;
  localparam int COL_CIRCLE_GREEN = 3;
  localparam int COL_STATUS_RED   = 4;
  localparam int COL_STATUS_BLUE  = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic logic is_one_hot(input logic [COL_W-1:0] v);
    return (v != '0) && ((v & (v - COL_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/joystick_board_responder_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with registered-history rise/fall pulses.
module responder_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;

endmodule

// File: rtl/joystick_board_responder.sv
// Serial slave for the joystick board: receives LED/header frames, returns switch/header state.
// Optional LED matrix decode is enabled with `define JOYSTICK_RESPONDER_LED_DECODE_EN.
module joystick_board_responder
  import joystick_board_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              LOAD,
  input  logic              SCLK,
  input  logic              MST_OUT_SLV_IN,
  output logic              MST_IN_SLV_OUT,
  input  logic [7:0]        slide_switches,
  input  logic [4:0]        joystick_switches,
  input  logic [HDR_W-1:0]  header_inputs,
  output logic [HDR_W-1:0]  header_outputs,
  output logic [ROW_W-1:0]  led_rows_n,
  output logic [COL_W-1:0]  led_columns,
  output logic [7:0]        slide_leds_red,
  output logic [7:0]        slide_leds_green,
  output logic [3:0]        status_leds_red,
  output logic [3:0]        status_leds_blue,
  output logic [11:0]       circle_leds_red,
  output logic [11:0]       circle_leds_green,
  output logic              frame_valid,
  output logic              frame_error
);

  logic load_level, load_rise, load_fall;
  logic sclk_level, sclk_rise, sclk_fall;
  logic mosi_level, mosi_rise, mosi_fall;

  responder_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
    .clk(clk), .reset(reset), .din(LOAD),
    .level(load_level), .rise(load_rise), .fall(load_fall)
  );

  responder_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(SCLK),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  responder_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(MST_OUT_SLV_IN),
    .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_edges;
  assign unused_edges = &{1'b0, load_level, sclk_level, mosi_rise, mosi_fall};

  state_t                  state_reg;
  logic [CNT_W-1:0]        count_reg;
  logic [FRAME_BITS-1:0]   rx_reg;
  logic [FRAME_BITS-1:0]   tx_reg;
  logic [HDR_W-1:0]        header_reg;
  logic [ROW_W-1:0]        rows_n_reg;
  logic [COL_W-1:0]        columns_reg;
  logic                    frame_valid_reg;
  logic                    frame_error_reg;

  logic [ROW_W-1:0] rx_rows_n;
  logic [COL_W-1:0] rx_col;
  logic [HDR_W-1:0] rx_hdr;
  logic             frame_end;
  logic             frame_good;
  logic             col_bad;

  assign rx_rows_n  = rx_reg[ROW_LSB +: ROW_W];
  assign rx_col     = rx_reg[COL_LSB +: COL_W];
  assign rx_hdr     = rx_reg[HDR_LSB +: HDR_W];
  assign frame_end  = (state_reg == ST_SHIFT) && load_rise;
  assign frame_good = frame_end && (count_reg == CNT_W'(FRAME_BITS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      count_reg       <= '0;
      rx_reg          <= '0;
      tx_reg          <= '0;
      header_reg      <= '0;
      rows_n_reg      <= '1;
      columns_reg     <= '0;
      frame_valid_reg <= 1'b0;
      frame_error_reg <= 1'b0;
    end else begin
      frame_valid_reg <= 1'b0;
      frame_error_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (load_fall) begin
            state_reg <= ST_SHIFT;
            count_reg <= '0;
          end
          // Reply is captured between frames so it is stable for the whole next frame
          if (sclk_rise) begin
            tx_reg <= {header_inputs, ~slide_switches, 3'b000, ~joystick_switches};
          end
        end
        ST_SHIFT: begin
          if (load_rise) begin
            state_reg <= ST_IDLE;
            if (frame_good) begin
              header_reg      <= rx_hdr;
              rows_n_reg      <= rx_rows_n;
              columns_reg     <= rx_col;
              frame_valid_reg <= 1'b1;
              frame_error_reg <= col_bad;
            end else begin
              frame_error_reg <= 1'b1;
            end
          end else begin
            if (sclk_rise) begin
              rx_reg <= {rx_reg[FRAME_BITS-2:0], mosi_level};
              if (count_reg != '1) begin
                count_reg <= count_reg + CNT_W'(1);
              end
            end
            if (sclk_fall) begin
              tx_reg <= {tx_reg[FRAME_BITS-2:0], 1'b0};
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign MST_IN_SLV_OUT = tx_reg[FRAME_BITS-1];
  assign header_outputs = header_reg;
  assign led_rows_n     = rows_n_reg;
  assign led_columns    = columns_reg;
  assign frame_valid    = frame_valid_reg;
  assign frame_error    = frame_error_reg;

`ifdef JOYSTICK_RESPONDER_LED_DECODE_EN
  logic [ROW_W-1:0] rows_on;
  logic [7:0]       slide_red_reg, slide_green_reg;
  logic [11:0]      circle_red_reg, circle_green_reg;
  logic [3:0]       status_red_reg, status_blue_reg;

  assign rows_on = ~rx_rows_n;
  assign col_bad = !is_one_hot(rx_col);

  // Only the group named by the column is refreshed; the rest keep their last image
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slide_red_reg    <= '0;
      slide_green_reg  <= '0;
      circle_red_reg   <= '0;
      circle_green_reg <= '0;
      status_red_reg   <= '0;
      status_blue_reg  <= '0;
    end else if (frame_good && !col_bad) begin
      if (rx_col[COL_SLIDE_RED])    slide_red_reg         <= rows_on;
      if (rx_col[COL_SLIDE_GREEN])  slide_green_reg       <= rows_on;
      if (rx_col[COL_CIRCLE_RED])   circle_red_reg[7:0]   <= rows_on;
      if (rx_col[COL_CIRCLE_GREEN]) circle_green_reg[7:0] <= rows_on;
      if (rx_col[COL_STATUS_RED])   {status_red_reg, circle_red_reg[11:8]}    <= rows_on;
      if (rx_col[COL_STATUS_BLUE])  {status_blue_reg, circle_green_reg[11:8]} <= rows_on;
    end
  end

  assign slide_leds_red    = slide_red_reg;
  assign slide_leds_green  = slide_green_reg;
  assign circle_leds_red   = circle_red_reg;
  assign circle_leds_green = circle_green_reg;
  assign status_leds_red   = status_red_reg;
  assign status_leds_blue  = status_blue_reg;
`else
  assign col_bad           = 1'b0;
  assign slide_leds_red    = '0;
  assign slide_leds_green  = '0;
  assign circle_leds_red   = '0;
  assign circle_leds_green = '0;
  assign status_leds_red   = '0;
  assign status_leds_blue  = '0;
`endif

endmodule

// File: tb/tb_joystick_board_responder.sv
// Scoreboard bench for joystick_board_responder: directed frames, queued expectations, pulse monitor.
module tb_joystick_board_responder;

  localparam int SYNC = 2;
  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        LOAD, SCLK, MOSI, MISO;
  logic [7:0]  slide_switches;
  logic [4:0]  joystick_switches;
  logic [7:0]  header_inputs;
  logic [7:0]  header_outputs, led_rows_n;
  logic [5:0]  led_columns;
  logic [7:0]  slide_leds_red, slide_leds_green;
  logic [3:0]  status_leds_red, status_leds_blue;
  logic [11:0] circle_leds_red, circle_leds_green;
  logic        frame_valid, frame_error;

  joystick_board_responder #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset),
    .LOAD(LOAD), .SCLK(SCLK), .MST_OUT_SLV_IN(MOSI), .MST_IN_SLV_OUT(MISO),
    .slide_switches(slide_switches), .joystick_switches(joystick_switches),
    .header_inputs(header_inputs), .header_outputs(header_outputs),
    .led_rows_n(led_rows_n), .led_columns(led_columns),
    .slide_leds_red(slide_leds_red), .slide_leds_green(slide_leds_green),
    .status_leds_red(status_leds_red), .status_leds_blue(status_leds_blue),
    .circle_leds_red(circle_leds_red), .circle_leds_green(circle_leds_green),
    .frame_valid(frame_valid), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        v;
    logic        e;
    logic [7:0]  hdr;
    logic [7:0]  rows_n;
    logic [5:0]  col;
    logic [47:0] leds;
    int          t0;
  } exp_t;

  exp_t sb_q[$];
  exp_t mx;

  logic [7:0]  m_hdr, m_rows, m_sr, m_sg;
  logic [5:0]  m_col;
  logic [11:0] m_cr, m_cg;
  logic [3:0]  m_str, m_stb;

`ifdef JOYSTICK_RESPONDER_LED_DECODE_EN
  localparam logic DECODE = 1'b1;
`else
  localparam logic DECODE = 1'b0;
`endif

  function automatic logic [47:0] act_leds();
    return {slide_leds_red, slide_leds_green, circle_leds_red, circle_leds_green,
            status_leds_red, status_leds_blue};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  task automatic model_reset();
    m_hdr = 8'h00; m_rows = 8'hFF; m_col = 6'h00;
    m_sr = '0; m_sg = '0; m_cr = '0; m_cg = '0; m_str = '0; m_stb = '0;
  endtask

  // Expected outcome of a frame that ended with nbits clocked in
  task automatic model_frame(input logic [23:0] d, input int nbits);
    exp_t x;
    logic [7:0] rows;
    x.v = 1'b0;
    x.e = 1'b0;
    if (nbits == 24) begin
      x.v = 1'b1;
      m_hdr = d[7:0]; m_rows = d[23:16]; m_col = d[13:8];
      if (DECODE) begin
        rows = ~d[23:16];
        case (d[13:8])
          6'h01: m_sr = rows;
          6'h02: m_sg = rows;
          6'h04: m_cr[7:0] = rows;
          6'h08: m_cg[7:0] = rows;
          6'h10: {m_str, m_cr[11:8]} = rows;
          6'h20: {m_stb, m_cg[11:8]} = rows;
          default: x.e = 1'b1;
        endcase
      end
    end else begin
      x.e = 1'b1;
    end
    x.hdr = m_hdr; x.rows_n = m_rows; x.col = m_col;
    x.leds = {m_sr, m_sg, m_cr, m_cg, m_str, m_stb};
    x.t0 = cyc;
    sb_q.push_back(x);
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [23:0] d, input int nbits,
                           input logic chk_miso, input logic [23:0] miso_exp);
    logic [23:0] got;
    got = '0;
    LOAD = 1'b0;
    wclk(HALF);
    for (int i = 0; i < nbits; i++) begin
      MOSI = (i < 24) ? d[23-i] : 1'b0;
      wclk(HALF);
      if (i < 24) got[23-i] = MISO;
      SCLK = 1'b1;
      wclk(HALF);
      SCLK = 1'b0;
    end
    wclk(HALF);
    if (chk_miso) check("miso_frame", {40'h0, got}, {40'h0, miso_exp});
  endtask

  task automatic end_frame(input logic [23:0] d, input int nbits);
    LOAD = 1'b1;
    model_frame(d, nbits);
    wclk(4 * HALF);
  endtask

  task automatic frame(input logic [23:0] d);
    send_bits(d, 24, 1'b0, 24'h0);
    end_frame(d, 24);
  endtask

  // Monitor: every valid/error pulse consumes one expectation
  always @(negedge clk) begin
    if (!reset && (frame_valid || frame_error)) begin
      if (sb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_pulse: valid=%b error=%b, expected no pulse", frame_valid, frame_error);
      end else begin
        mx = sb_q.pop_front();
        $display("[TB] frame at cyc %0d: valid=%b error=%b hdr=%h rows_n=%h col=%h",
                 cyc, frame_valid, frame_error, header_outputs, led_rows_n, led_columns);
        check("frame_valid", {63'h0, frame_valid}, {63'h0, mx.v});
        check("frame_error", {63'h0, frame_error}, {63'h0, mx.e});
        check("header_outputs", {56'h0, header_outputs}, {56'h0, mx.hdr});
        check("led_rows_n", {56'h0, led_rows_n}, {56'h0, mx.rows_n});
        check("led_columns", {58'h0, led_columns}, {58'h0, mx.col});
        check("decoded_leds", {16'h0, act_leds()}, {16'h0, mx.leds});
        check("latency", 64'(cyc - mx.t0), 64'(SYNC + 1));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; LOAD = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    slide_switches = 8'h00; joystick_switches = 5'h00; header_inputs = 8'h00;
    model_reset();
    wclk(5);
    reset = 1'b0;
    wclk(5);
    check("rst_header", {56'h0, header_outputs}, 64'h00);
    check("rst_rows_n", {56'h0, led_rows_n}, 64'hFF);
    check("rst_columns", {58'h0, led_columns}, 64'h00);
    check("rst_leds", {16'h0, act_leds()}, 64'h0);
    check("rst_miso", {63'h0, MISO}, 64'h0);
    check("rst_pulses", {62'h0, frame_valid, frame_error}, 64'h0);

    // Good frame, column 0
    frame(24'h0F01A5);
    check("s1_header", {56'h0, header_outputs}, 64'hA5);
    check("s1_slide_red", {56'h0, slide_leds_red}, DECODE ? 64'hF0 : 64'h00);

    // Reply path: load between frames, read back during next frame
    slide_switches = 8'h81; joystick_switches = 5'h04; header_inputs = 8'h3C;
    SCLK = 1'b1; wclk(HALF); SCLK = 1'b0; wclk(HALF);
    send_bits(24'hAA0211, 24, 1'b1, 24'h3C7E1B);
    end_frame(24'hAA0211, 24);
    check("s2_slide_green", {56'h0, slide_leds_green}, DECODE ? 64'h55 : 64'h00);

    // Short frame is rejected
    send_bits(24'hFF01EE, 23, 1'b0, 24'h0);
    end_frame(24'hFF01EE, 23);
    check("s3_header_hold", {56'h0, header_outputs}, 64'h11);

    // Non-one-hot column
    frame(24'h330377);
    check("s4_columns", {58'h0, led_columns}, 64'h03);
    check("s4_header", {56'h0, header_outputs}, 64'h77);

    // Overlong frame saturates the counter and is rejected
    send_bits(24'h00010F, 33, 1'b0, 24'h0);
    end_frame(24'h00010F, 33);
    check("s4b_header_hold", {56'h0, header_outputs}, 64'h77);

    // Reset in the middle of a frame
    send_bits(24'h1234FF, 12, 1'b0, 24'h0);
    reset = 1'b1;
    model_reset();
    wclk(3);
    reset = 1'b0;
    wclk(2);
    LOAD = 1'b1;
    wclk(4 * HALF);
    check("s5_rst_header", {56'h0, header_outputs}, 64'h00);
    check("s5_rst_rows_n", {56'h0, led_rows_n}, 64'hFF);
    frame(24'hC3045A);
    check("s5_header", {56'h0, header_outputs}, 64'h5A);

    // Sweep every column with all rows on
    for (int c = 0; c < 6; c++) begin
      logic [5:0] col;
      col = 6'(1 << c);
      frame({8'h00, 2'b00, col, 8'(8'h60 + c)});
    end
    check("s6_all_leds", {16'h0, act_leds()}, DECODE ? 64'hFFFF_FFFF_FFFF : 64'h0);
    check("s6_header", {56'h0, header_outputs}, 64'h65);

    wclk(20);
    check("scoreboard_drained", 64'(sb_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
